// File: rtl/btn_updown_counter.sv
// Three-button up/down/clear counter: 2-flop sync, per-button debounce, auto-repeat on up/down.
// leds change on edge 3+DEBOUNCE_CYCLES after a clean press; push-button inputs, so no backpressure.
module btn_updown_counter #(
  parameter int CNT_WIDTH       = 4,
  parameter int DEBOUNCE_CYCLES = 256,
  parameter int REPEAT_DELAY    = 0,
  parameter int REPEAT_PERIOD   = 64,
  parameter int SATURATE        = 0
) (
  input  logic                 CLK_IN,
  input  logic                 CPU_RESETN,
  input  logic                 BTNU,
  input  logic                 BTND,
  input  logic                 BTNC,
  output logic [CNT_WIDTH-1:0] leds,
  output logic [2:0]           btn_db,
  output logic                 step_pulse,
  output logic                 limit_hit
);

  localparam int DCW  = $clog2(DEBOUNCE_CYCLES);
  localparam int TMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int TW   = $clog2(TMAX + 1);
  localparam logic [DCW-1:0] DC_LAST = DCW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {RELEASED, HELD, REPEAT} rpt_state_e;

  logic [2:0]          meta_q, sync_q;
  logic [2:0]          db_q, db_d, db_prev_q;
  logic [2:0][DCW-1:0] dc_q, dc_d;
  logic [2:0]          press;
  logic [1:0]          req;

  logic [CNT_WIDTH-1:0] leds_q, leds_d;
  logic                 step_q, step_d;
  logic                 limit_q, limit_d;

  always_ff @(posedge CLK_IN or negedge CPU_RESETN) begin
    if (!CPU_RESETN) begin
      meta_q    <= '0;
      sync_q    <= '0;
      db_q      <= '0;
      db_prev_q <= '0;
      dc_q      <= '0;
      leds_q    <= '0;
      step_q    <= 1'b0;
      limit_q   <= 1'b0;
    end else begin
      meta_q    <= {BTNC, BTND, BTNU};
      sync_q    <= meta_q;
      db_q      <= db_d;
      db_prev_q <= db_q;
      dc_q      <= dc_d;
      leds_q    <= leds_d;
      step_q    <= step_d;
      limit_q   <= limit_d;
    end
  end

  // Any sample matching the current level restarts the stability count.
  always_comb begin
    db_d = db_q;
    dc_d = '0;
    for (int i = 0; i < 3; i++) begin
      if (sync_q[i] != db_q[i]) begin
        if (dc_q[i] == DC_LAST) begin
          db_d[i] = ~db_q[i];
        end else begin
          dc_d[i] = dc_q[i] + DCW'(1);
        end
      end
    end
  end

  assign press = db_q & ~db_prev_q;

  for (genvar g = 0; g < 2; g++) begin : g_rpt
    rpt_state_e    st_q, st_d;
    logic [TW-1:0] tmr_q, tmr_d;
    logic          rq;

    always_ff @(posedge CLK_IN or negedge CPU_RESETN) begin
      if (!CPU_RESETN) begin
        st_q  <= RELEASED;
        tmr_q <= '0;
      end else begin
        st_q  <= st_d;
        tmr_q <= tmr_d;
      end
    end

    always_comb begin
      st_d  = st_q;
      tmr_d = tmr_q;
      rq    = 1'b0;
      if (!db_q[g]) begin
        st_d  = RELEASED;
        tmr_d = '0;
      end else begin
        case (st_q)
          RELEASED: begin
            if (press[g]) begin
              rq    = 1'b1;
              st_d  = HELD;
              tmr_d = '0;
            end
          end
          HELD: begin
            // A zero delay parks the channel here until release.
            if (REPEAT_DELAY != 0) begin
              if (tmr_q == TW'(REPEAT_DELAY - 1)) begin
                rq    = 1'b1;
                st_d  = REPEAT;
                tmr_d = '0;
              end else begin
                tmr_d = tmr_q + TW'(1);
              end
            end
          end
          REPEAT: begin
            if (tmr_q == TW'(REPEAT_PERIOD - 1)) begin
              rq    = 1'b1;
              tmr_d = '0;
            end else begin
              tmr_d = tmr_q + TW'(1);
            end
          end
          default: st_d = RELEASED;
        endcase
      end
    end

    assign req[g] = rq;
  end

  always_comb begin
    leds_d  = leds_q;
    step_d  = 1'b0;
    limit_d = 1'b0;
    if (press[2]) begin
      leds_d = '0;
      step_d = 1'b1;
    end else if (req[0] && !req[1]) begin
      if (&leds_q) begin
        limit_d = 1'b1;
        if (SATURATE == 0) begin
          leds_d = '0;
          step_d = 1'b1;
        end
      end else begin
        leds_d = leds_q + CNT_WIDTH'(1);
        step_d = 1'b1;
      end
    end else if (req[1] && !req[0]) begin
      if (leds_q == '0) begin
        limit_d = 1'b1;
        if (SATURATE == 0) begin
          leds_d = '1;
          step_d = 1'b1;
        end
      end else begin
        leds_d = leds_q - CNT_WIDTH'(1);
        step_d = 1'b1;
      end
    end
  end

  assign leds       = leds_q;
  assign btn_db     = db_q;
  assign step_pulse = step_q;
  assign limit_hit  = limit_q;

endmodule

// File: tb/tb_btn_updown_counter.sv
// Directed bench for btn_updown_counter: three instances (plain wrap, auto-repeat, saturate)
// share one set of button and reset stimulus; outputs are sampled 1 time unit after each rising edge.
module tb_btn_updown_counter;

  logic clk;
  logic rst_n;
  logic btnu, btnd, btnc;

  logic [3:0] leds_a, leds_b, leds_c;
  logic [2:0] db_a, db_b, db_c;
  logic       sp_a, sp_b, sp_c;
  logic       lh_a, lh_b, lh_c;

  int n_checks = 0;
  int n_fail   = 0;
  int steps;
  logic saw;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  btn_updown_counter #(.CNT_WIDTH(4), .DEBOUNCE_CYCLES(8), .REPEAT_DELAY(0),
                       .REPEAT_PERIOD(64), .SATURATE(0)) dut_a (
    .CLK_IN(clk), .CPU_RESETN(rst_n), .BTNU(btnu), .BTND(btnd), .BTNC(btnc),
    .leds(leds_a), .btn_db(db_a), .step_pulse(sp_a), .limit_hit(lh_a));

  btn_updown_counter #(.CNT_WIDTH(4), .DEBOUNCE_CYCLES(8), .REPEAT_DELAY(20),
                       .REPEAT_PERIOD(5), .SATURATE(0)) dut_b (
    .CLK_IN(clk), .CPU_RESETN(rst_n), .BTNU(btnu), .BTND(btnd), .BTNC(btnc),
    .leds(leds_b), .btn_db(db_b), .step_pulse(sp_b), .limit_hit(lh_b));

  btn_updown_counter #(.CNT_WIDTH(4), .DEBOUNCE_CYCLES(8), .REPEAT_DELAY(0),
                       .REPEAT_PERIOD(64), .SATURATE(1)) dut_c (
    .CLK_IN(clk), .CPU_RESETN(rst_n), .BTNU(btnu), .BTND(btnd), .BTNC(btnc),
    .leds(leds_c), .btn_db(db_c), .step_pulse(sp_c), .limit_hit(lh_c));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step_edges(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step_edges(2);
    rst_n = 1'b1;
  endtask

  // Drive a button pattern and land just after the edge where the step should apply.
  task automatic press_btn(input logic [2:0] m);
    {btnc, btnd, btnu} = m;
    step_edges(11);
  endtask

  task automatic release_btns();
    {btnc, btnd, btnu} = 3'b000;
    step_edges(15);
  endtask

  initial begin
    rst_n = 1'b1;
    {btnc, btnd, btnu} = 3'b000;
    #2 rst_n = 1'b0;
    #1;
    check("rst_leds", 32'(leds_a), 0);
    check("rst_db", 32'(db_a), 0);
    check("rst_strobes", 32'({sp_a, lh_a, sp_b, lh_b}), 0);
    step_edges(3);
    rst_n = 1'b1;

    // Single press, no repeat: step lands exactly 11 edges after the pin rises.
    btnu = 1'b1;
    step_edges(10);
    check("deb_db_rise", 32'(db_a), 32'h1);
    check("deb_leds_before", 32'(leds_a), 0);
    step_edges(1);
    check("deb_leds_step", 32'(leds_a), 1);
    check("deb_step_pulse", 32'(sp_a), 1);
    step_edges(1);
    check("deb_step_one_cycle", 32'(sp_a), 0);
    step_edges(30);
    check("deb_no_repeat", 32'(leds_a), 1);
    btnu = 1'b0;
    step_edges(20);
    check("deb_db_fall", 32'(db_a), 0);

    // Bouncing input shorter than the debounce window.
    saw = 1'b0;
    for (int k = 0; k < 20; k++) begin
      btnu = ~btnu;
      for (int j = 0; j < 5; j++) begin
        step_edges(1);
        if (db_a[0]) saw = 1'b1;
      end
    end
    step_edges(15);
    check("bounce_db_rise", 32'(saw), 0);
    check("bounce_leds", 32'(leds_a), 1);

    // Auto-repeat: steps at edges 11,31,36,...,66; pin drops after edge 58.
    do_reset();
    btnu = 1'b1;
    steps = 0;
    for (int e = 1; e <= 90; e++) begin
      step_edges(1);
      if (sp_b) steps++;
      if (e == 11) check("rpt_first", 32'(leds_b), 1);
      if (e == 30) check("rpt_delay_wait", 32'(leds_b), 1);
      if (e == 31) check("rpt_second", 32'(leds_b), 2);
      if (e == 36) check("rpt_third", 32'(leds_b), 3);
      if (e == 58) btnu = 1'b0;
      if (e == 67) check("rpt_db_still_high", 32'(db_b[0]), 1);
      if (e == 68) check("rpt_db_fall", 32'(db_b[0]), 0);
    end
    check("rpt_step_count", 32'(steps), 9);
    check("rpt_leds_final", 32'(leds_b), 9);

    // Wrap on up at all-ones versus saturate.
    do_reset();
    for (int k = 0; k < 15; k++) begin
      press_btn(3'b001);
      release_btns();
    end
    check("wrap_pre_a", 32'(leds_a), 15);
    check("sat_pre_c", 32'(leds_c), 15);
    press_btn(3'b001);
    check("wrap_up_leds", 32'(leds_a), 0);
    check("wrap_up_flags", 32'({sp_a, lh_a}), 32'h3);
    check("sat_up_leds", 32'(leds_c), 15);
    check("sat_up_flags", 32'({sp_c, lh_c}), 32'h1);
    release_btns();

    // Down at zero: saturating instance blocks, wrapping one goes to all-ones.
    do_reset();
    press_btn(3'b010);
    check("sat_dn_leds", 32'(leds_c), 0);
    check("sat_dn_flags", 32'({sp_c, lh_c}), 32'h1);
    check("wrap_dn_leds", 32'(leds_a), 15);
    check("wrap_dn_flags", 32'({sp_a, lh_a}), 32'h3);
    release_btns();

    // Simultaneous up+down cancel; clear beats up; held clear does not block up.
    do_reset();
    press_btn(3'b011);
    check("ud_db", 32'(db_a), 32'h3);
    check("ud_leds", 32'(leds_a), 0);
    check("ud_strobes", 32'({sp_a, lh_a}), 0);
    release_btns();
    press_btn(3'b001);
    check("cu_pre", 32'(leds_a), 1);
    release_btns();
    press_btn(3'b101);
    check("cu_leds", 32'(leds_a), 0);
    check("cu_step", 32'({sp_a, lh_a}), 32'h2);
    btnu = 1'b0;
    step_edges(15);
    btnu = 1'b1;
    step_edges(11);
    check("c_held_up_leds", 32'(leds_a), 1);
    release_btns();

    // Reset mid-repeat with the button still held through release.
    do_reset();
    btnu = 1'b1;
    step_edges(56);
    check("mid_rpt_leds", 32'(leds_b), 7);
    #3 rst_n = 1'b0;
    #1;
    check("async_rst_leds", 32'(leds_b), 0);
    check("async_rst_db", 32'(db_b), 0);
    check("async_rst_strobes", 32'({sp_b, lh_b}), 0);
    step_edges(3);
    rst_n = 1'b1;
    step_edges(10);
    check("post_rst_no_step", 32'(leds_b), 0);
    step_edges(1);
    check("post_rst_leds", 32'(leds_b), 1);
    check("post_rst_pulse", 32'(sp_b), 1);
    btnu = 1'b0;
    step_edges(5);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/btn_updown_counter.md
Name: btn_updown_counter

Overview:
- Parametrised successor to the single-button LED counter: three independently synchronised and debounced buttons drive an up/down/clear counter.
- Adds auto-repeat on held up/down buttons and a selectable wrap or saturate mode.
- Sits between board push-buttons (asynchronous human domain) and the LED bank; fully PL-only, single clock domain.

Parameters:
- CNT_WIDTH, 4: counter and leds width, minimum 1.
- DEBOUNCE_CYCLES, 256: consecutive stable cycles required before a debounced level changes, minimum 2.
- REPEAT_DELAY, 0: cycles a debounced up/down must stay held before auto-repeat starts; 0 disables auto-repeat.
- REPEAT_PERIOD, 64: cycles between auto-repeat pulses, minimum 1.
- SATURATE, 0: 0 = wrap modulo 2^CNT_WIDTH; 1 = clamp at 0 and at all-ones.

Ports:
- CLK_IN  input  1  system clock.
- CPU_RESETN  input  1  asynchronous active-low reset.
- BTNU  input  1  raw async up button, active-high.
- BTND  input  1  raw async down button, active-high.
- BTNC  input  1  raw async clear button, active-high.
- leds  output  CNT_WIDTH  current count.
- btn_db  output  3  debounced levels {C,D,U}.
- step_pulse  output  1  one-cycle strobe on every applied count change, including clear.
- limit_hit  output  1  one-cycle strobe when a step wraps (SATURATE=0) or is blocked at a limit (SATURATE=1).

Behaviour:
- Reset, asynchronous while CPU_RESETN=0:
  - leds=0, btn_db=0, step_pulse=0, limit_hit=0.
  - All sync flops, debounce counters and repeat FSMs cleared to RELEASED.
  - Release is synchronous to CLK_IN.
- Synchroniser: 2-flop per button; sync output s[i] lags the pin by 2 edges.
- Debounce, per channel:
  - Counter dc[i], sized clog2(DEBOUNCE_CYCLES).
  - If s[i]==btn_db[i], dc[i] clears.
  - Otherwise dc[i] increments; on the edge where dc[i]==DEBOUNCE_CYCLES-1, btn_db[i] toggles and dc[i] clears.
  - Any glitch back to the current level before then restarts the count.
- Press event: press[i]=1 for exactly the one cycle in which btn_db[i] has just risen, from a registered compare. Release generates no event.
- Repeat FSM, per up/down channel; REPEAT_DELAY=0 keeps the FSM in RELEASED/HELD with no repeats.
  - RELEASED: on press -> emit step request, go HELD with timer=0.
  - HELD: timer++ each cycle; on timer==REPEAT_DELAY-1 -> emit request, go REPEAT with timer=0.
  - REPEAT: timer++; on timer==REPEAT_PERIOD-1 -> emit request, timer=0.
  - Any state: btn_db[i]==0 -> RELEASED immediately, with no request that cycle.
- Counter update, registered on the edge after the request cycle; priority:
  - clear (press[C]) > simultaneous up+down (both requests cancel, no step, no strobe) > up > down.
  - Clear: leds=0, step_pulse=1, limit_hit=0.
  - Up at all-ones: SATURATE=0 -> 0 with limit_hit=1, step_pulse=1; SATURATE=1 -> unchanged, limit_hit=1, step_pulse=0.
  - Down at 0: mirror of the up case.
- Latency: pin stable high at edge 0 -> btn_db high at edge 2+DEBOUNCE_CYCLES -> leds updated at edge 3+DEBOUNCE_CYCLES.
- Holding C does not repeat, and C held does not block up/down presses once its single press event has passed.
- Reset mid-debounce or mid-repeat discards all partial counts; a button held through reset release must re-debounce as a new press.

Test Plan:
1. DEBOUNCE_CYCLES=8, BTNU high steady: leds 0->1 exactly 11 edges after the pin rises; step_pulse high one cycle; no further change while held (REPEAT_DELAY=0).
2. BTNU toggling every 5 cycles for 100 cycles, then low: leds stays 0, btn_db[0] never rises.
3. REPEAT_DELAY=20, REPEAT_PERIOD=5, BTNU held 60 cycles after debounce: steps at +0, +20, +25 ... +55 relative to the press event (9 steps), leds=9; release stops repeats immediately.
4. CNT_WIDTH=4, SATURATE=0, leds=15, press U: leds=0, limit_hit=1. SATURATE=1, leds=0, press D: leds=0, limit_hit=1, step_pulse=0.
5. U and D debounced on the same edge: no change, no strobes. C+U on the same edge: leds=0, step_pulse=1.
6. Assert CPU_RESETN=0 mid-repeat with leds=7: all outputs 0 asynchronously. Release with BTNU still high: first new step after 8 debounce cycles, leds=1.
